uart_receiver: RTL and testbench

Receive stage paired with the UART transmitter: deserialises the `uart_tx_o` line (driven into `uart_rx_i`) into bytes and buffers them in an on-chip FIFO for a parallel consumer. Shares the transmitter's baud-rate selection and threshold conventions, so a loopback bench can connect the transmitter output straight to this block. Format is fixed: 8N1, LSB first, 16x oversampling.

---
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1, LSB-first, 16x-oversampled UART receive stage with a
// show-ahead receive FIFO, occupancy threshold flag and sticky error flags.
// Optional feature macro: UART_RX_FRAME_CHECK_EN (when defined, a low stop
// bit sets frame_error_o and the byte is dropped; otherwise every completed
// frame is pushed and frame_error_o is tied low).
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic       clock,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  input  logic       data_read_i,
  input  logic [5:0] data_buffer_full_tresh_i,
  output logic [7:0] data_o,
  output logic       data_buffer_empty_o,
  output logic       data_buffer_full_o,
  output logic       overrun_o,
  output logic       frame_error_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [19:0] DIV_9600   = 20'(CLK_FREQ_HZ / (9600 * 16));
  localparam logic [19:0] DIV_19200  = 20'(CLK_FREQ_HZ / (19200 * 16));
  localparam logic [19:0] DIV_57600  = 20'(CLK_FREQ_HZ / (57600 * 16));
  localparam logic [19:0] DIV_115200 = 20'(CLK_FREQ_HZ / (115200 * 16));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      state_q, state_d;
  logic [1:0]      baud_q, baud_d;
  logic [19:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            push_q, push_d;
  logic [7:0]      push_data_q;
  logic            frame_err_d;
  logic [19:0]     div;
  logic            tick, sample, fall;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overrun_q;
  logic            pop, push_ok;
  logic [6:0]      thr;

  // Divider selected by the baud rate latched at frame start
  always_comb begin
    case (baud_q)
      2'd0:    div = DIV_9600;
      2'd1:    div = DIV_19200;
      2'd2:    div = DIV_57600;
      default: div = DIV_115200;
    endcase
  end

  assign tick   = (tick_cnt_q == div - 20'd1);
  assign sample = tick && (phase_q == 4'd7);
  assign fall   = rx_prev_q && !rx_sync_q;

  // Receive FSM next-state: oversampling counters, bit shifting, push request
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    tick_cnt_d  = tick ? 20'd0 : tick_cnt_q + 20'd1;
    phase_d     = tick ? phase_q + 4'd1 : phase_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d     = baudrate_select_i;
        tick_cnt_d = 20'd0;
        phase_d    = 4'd0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (sample) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d[bit_idx_q] = rx_sync_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: begin
        if (sample) begin
          state_d = S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
          push_d      = rx_sync_q;
          frame_err_d = !rx_sync_q;
`else
          push_d      = 1'b1;
`endif
        end
      end
    endcase
  end

  // Control state: synchroniser, FSM, counters and the registered push strobe
  always_ff @(posedge clock) begin
    if (!reset_n_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= 2'd0;
      tick_cnt_q <= 20'd0;
      phase_q    <= 4'd0;
      bit_idx_q  <= 3'd0;
      push_q     <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      push_q     <= push_d;
    end
  end

  // Datapath registers: shift register and byte handed to the FIFO
  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
    if (push_d) push_data_q <= shreg_q;
  end

`ifdef UART_RX_FRAME_CHECK_EN
  logic frame_err_q;
  // Sticky frame error, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset_n_i) frame_err_q <= 1'b0;
    else if (frame_err_d) frame_err_q <= 1'b1;
  end
  assign frame_error_o = frame_err_q;
`else
  assign frame_error_o = 1'b0;
`endif

  // A push into a full FIFO is still accepted when a pop frees a slot
  assign pop     = data_read_i && (count_q != '0);
  assign push_ok = push_q && ((count_q != CW'(FIFO_DEPTH)) || data_read_i);

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clock) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop);
      if (push_q && !push_ok) overrun_q <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_q;
  end

  assign thr = ((data_buffer_full_tresh_i == 6'd0) ||
                ({1'b0, data_buffer_full_tresh_i} > 7'(FIFO_DEPTH)))
               ? 7'(FIFO_DEPTH) : {1'b0, data_buffer_full_tresh_i};

  assign data_o              = (count_q == '0) ? 8'h00 : mem[rd_ptr_q];
  assign data_buffer_empty_o = (count_q == '0);
  assign data_buffer_full_o  = (7'(count_q) >= thr);
  assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed, table-driven bench for uart_receiver. Runs the DUT at a reduced
// clock (7.3728 MHz) so that every baud divider is exact and the long
// overrun sequence stays short.
module tb_uart_receiver;

  localparam int CLK_HZ = 7_372_800;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [1:0] baud_sel;
  logic       rd;
  logic [5:0] thresh;
  logic [7:0] data;
  logic       empty, full, ovr, ferr;

  int tests = 0;
  int fails = 0;

  uart_receiver #(.CLK_FREQ_HZ(CLK_HZ), .FIFO_DEPTH(32)) dut (
    .clock                   (clk),
    .reset_n_i               (rst_n),
    .uart_rx_i               (rx),
    .baudrate_select_i       (baud_sel),
    .data_read_i             (rd),
    .data_buffer_full_tresh_i(thresh),
    .data_o                  (data),
    .data_buffer_empty_o     (empty),
    .data_buffer_full_o      (full),
    .overrun_o               (ovr),
    .frame_error_o           (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic       exp_empty;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [5];

  function automatic int bit_cycles(input logic [1:0] sel);
    int baud;
    case (sel)
      2'd0:    baud = 9600;
      2'd1:    baud = 19200;
      2'd2:    baud = 57600;
      default: baud = 115200;
    endcase
    return 16 * (CLK_HZ / (baud * 16));
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    rx = 1'b0;
    cyc(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(bc);
    end
    rx = stop;
    cyc(bc);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    int bc;
    int nonempty;

    vecs[0] = '{8'hA5, 1'b1, 2'd3, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 2'd2, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b0};
`ifdef UART_RX_FRAME_CHECK_EN
    vecs[4] = '{8'h3C, 1'b0, 2'd3, 8'h00, 1'b1, 1'b1};
`else
    vecs[4] = '{8'h3C, 1'b0, 2'd3, 8'h3C, 1'b0, 1'b0};
`endif

    rst_n = 1'b0; rx = 1'b1; baud_sel = 2'd3; rd = 1'b0; thresh = 6'd4;

    // Reset values
    cyc(5);
    chk("rst_data", data, 8'h00);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    rst_n = 1'b1;

    // Idle line stays empty
    nonempty = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc(1);
      if (!empty) nonempty++;
    end
    chk("idle_nonempty_cycles", nonempty, 0);

    // Glitch shorter than half a bit is rejected
    bc = bit_cycles(2'd3);
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(bc * 12);
    chk("glitch_empty", empty, 1'b1);

    // Single-frame vectors
    for (int v = 0; v < 5; v++) begin
      baud_sel = vecs[v].sel;
      cyc(2);
      bc = bit_cycles(vecs[v].sel);
      send_frame(vecs[v].din, vecs[v].stop, bc);
      cyc(bc);
      chk($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      chk($sformatf("vec%0d_empty", v), empty, vecs[v].exp_empty);
      chk($sformatf("vec%0d_ferr", v), ferr, vecs[v].exp_ferr);
      if (!vecs[v].exp_empty) begin
        pop_one();
        chk($sformatf("vec%0d_empty_after_pop", v), empty, 1'b1);
      end
    end

    // Threshold, fill and overrun
    baud_sel = 2'd3;
    thresh = 6'd4;
    cyc(2);
    bc = bit_cycles(2'd3);
    for (int i = 0; i < 33; i++) begin
      send_frame(8'(i), 1'b1, bc);
      cyc(16);
      if (i < 32) chk($sformatf("full_after_%0d", i + 1), full, (i + 1 >= 4) ? 1'b1 : 1'b0);
      if (i == 30) begin
        thresh = 6'd0;  #1; chk("thr0_31", full, 1'b0);
        thresh = 6'd63; #1; chk("thr63_31", full, 1'b0);
        thresh = 6'd31; #1; chk("thr31_31", full, 1'b1);
        thresh = 6'd4;
      end
      if (i == 31) begin
        thresh = 6'd0; #1; chk("thr0_32", full, 1'b1);
        thresh = 6'd4;
        chk("ovr_before_33", ovr, 1'b0);
      end
    end
    chk("ovr_after_33", ovr, 1'b1);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("pop_data_%0d", j), data, 8'(j));
      pop_one();
    end
    chk("drain_empty", empty, 1'b1);
    chk("drain_full", full, 1'b0);
    chk("ovr_sticky", ovr, 1'b1);

    // Reset during the data bits of 0x55 aborts the frame
    rx = 1'b0;
    cyc(bc);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc(bc);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(bc * 12);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_ovr", ovr, 1'b0);
    chk("midrst_ferr", ferr, 1'b0);

    // Slowest baud after reset
    baud_sel = 2'd0;
    cyc(2);
    bc = bit_cycles(2'd0);
    send_frame(8'h81, 1'b1, bc);
    cyc(bc);
    chk("b9600_data", data, 8'h81);
    chk("b9600_empty", empty, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
